// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Control plane for a block-wide in-order 5-stage SIMT pipeline
//               (IF/ID/EX/MEM/WB). Tracks stage valids and destination tags,
//               detects RAW hazards, stalls on busy LSUs, flushes on taken
//               branches and drains the pipeline on RET.
//               Optional feature macro: FORWARDING_EN (MEM/WB operand
//               forwarding instead of RAW stalls).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int REG_ADDR_BITS     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic                                 if_valid,
    input  logic [PC_BITS-1:0]                   if_pc,
    output logic                                 if_ready,
    input  logic [REG_ADDR_BITS-1:0]             id_rs,
    input  logic [REG_ADDR_BITS-1:0]             id_rt,
    input  logic [REG_ADDR_BITS-1:0]             id_rd,
    input  logic                                 id_reg_write,
    input  logic                                 id_mem,
    input  logic                                 id_load,
    input  logic                                 id_ret,
    input  logic [THREADS_PER_BLOCK-1:0]         mem_busy,
    input  logic                                 branch_taken,
    input  logic [PC_BITS-1:0]                   branch_target,
    output logic [4:0]                           stage_valid,
    output logic                                 stall,
    output logic                                 flush,
    output logic                                 redirect_valid,
    output logic [PC_BITS-1:0]                   redirect_pc,
    output logic [1:0]                           fwd_rs_sel,
    output logic [1:0]                           fwd_rt_sel,
    output logic                                 done
);

    localparam int c_TC_W = $clog2(THREADS_PER_BLOCK) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Stage valids: [0]=IF [1]=ID [2]=EX [3]=MEM [4]=WB.
    logic [4:0]               r_valid;
    // Decoded tags exist from EX onward; the ID tags come straight from the decoder.
    logic [REG_ADDR_BITS-1:0] r_rd [2:4];
    logic [4:2]               r_rw;
    logic [4:2]               r_ret;
    logic [3:2]               r_mem;
    logic [3:2]               r_load;

    logic [THREADS_PER_BLOCK-1:0] w_active;
    logic [4:2]               w_rs_hit;
    logic [4:2]               w_rt_hit;
    logic                     w_mem_stall;
    logic                     w_hazard_raw;
    logic                     w_hazard;
    logic                     w_flush;
    logic                     w_ret_in_id;
    logic                     w_to_drain;
    logic                     w_front_kill;
    logic                     w_fetch;
    logic                     w_unused_ok;

    // Lane i participates in the LSU stall only when it is below thread_count.
    genvar gi;
    generate
        for (gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
            assign w_active[gi] = (thread_count > c_TC_W'(gi));
        end
    endgenerate

    assign w_mem_stall  = r_valid[3] & r_mem[3] & (|(mem_busy & w_active));
    // A branch waits in EX while MEM is frozen; it re-presents once the stall clears.
    assign w_flush      = r_valid[2] & branch_taken & ~w_mem_stall;
    // A flushed ID instruction cannot cause a hazard.
    assign w_hazard     = w_hazard_raw & ~w_flush;
    assign stall        = w_mem_stall | w_hazard;
    assign w_ret_in_id  = r_valid[1] & id_ret;
    assign w_to_drain   = (r_state == S_RUN) & w_ret_in_id & ~stall & ~w_flush;
    // Instructions fetched behind a RET (or on the wrong path) never reach EX.
    assign w_front_kill = w_flush | w_to_drain | (r_state != S_RUN);
    assign w_fetch      = if_valid & if_ready;

    assign stage_valid    = r_valid;
    assign flush          = w_flush;
    assign redirect_valid = w_flush;
    assign redirect_pc    = w_flush ? branch_target : '0;

    // Per-source register matches against in-flight writers, ID must be valid.
    always_comb begin
        w_rs_hit = '0;
        w_rt_hit = '0;
        for (int s = 2; s <= 4; s++) begin
            w_rs_hit[s] = r_valid[1] & r_valid[s] & r_rw[s] & (r_rd[s] == id_rs);
            w_rt_hit[s] = r_valid[1] & r_valid[s] & r_rw[s] & (r_rd[s] == id_rt);
        end
    end

`ifdef FORWARDING_EN
    // EX producers and loads still in MEM cannot be forwarded yet; the rest bypass.
    assign w_hazard_raw = (w_rs_hit[2] | w_rt_hit[2]) |
                          ((w_rs_hit[3] | w_rt_hit[3]) & r_load[3]);
    assign fwd_rs_sel   = w_rs_hit[3] ? 2'b01 : (w_rs_hit[4] ? 2'b10 : 2'b00);
    assign fwd_rt_sel   = w_rt_hit[3] ? 2'b01 : (w_rt_hit[4] ? 2'b10 : 2'b00);
    assign w_unused_ok  = &{1'b0, if_pc};
`else
    assign w_hazard_raw = |(w_rs_hit | w_rt_hit);
    assign fwd_rs_sel   = 2'b00;
    assign fwd_rt_sel   = 2'b00;
    assign w_unused_ok  = &{1'b0, if_pc, r_load};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-derived outputs.
    always_comb begin
        w_state_next = r_state;
        done         = 1'b0;
        if_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if_ready = ~stall & ~w_ret_in_id;
                if (w_to_drain) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_valid[4] & r_ret[4]) w_state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stage valid/tag advance: MEM stall freezes IF..MEM, hazard bubbles EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_rw    <= '0;
            r_ret   <= '0;
            r_mem   <= '0;
            r_load  <= '0;
            for (int s = 2; s <= 4; s++) begin
                r_rd[s] <= '0;
            end
        end else if (w_mem_stall) begin
            r_valid[4] <= 1'b0;
        end else begin
            r_valid[4] <= r_valid[3];
            r_rd[4]    <= r_rd[3];
            r_rw[4]    <= r_rw[3];
            r_ret[4]   <= r_ret[3];
            r_valid[3] <= r_valid[2];
            r_rd[3]    <= r_rd[2];
            r_rw[3]    <= r_rw[2];
            r_ret[3]   <= r_ret[2];
            r_mem[3]   <= r_mem[2];
            r_load[3]  <= r_load[2];
            if (w_hazard) begin
                r_valid[2] <= 1'b0;
            end else begin
                r_valid[2] <= r_valid[1] & ~w_flush;
                r_rd[2]    <= id_rd;
                r_rw[2]    <= id_reg_write;
                r_ret[2]   <= id_ret;
                r_mem[2]   <= id_mem;
                r_load[2]  <= id_load;
                r_valid[1] <= r_valid[0] & ~w_front_kill;
                r_valid[0] <= w_fetch & ~w_front_kill;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Each scenario builds a
//               per-cycle stimulus table with hand-derived expected outputs;
//               expectations are queued as stimulus is driven and compared
//               when the outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] thread_count;
    logic       if_valid;
    logic [7:0] if_pc;
    logic       if_ready;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_reg_write, id_mem, id_load, id_ret;
    logic [3:0] mem_busy;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [4:0] stage_valid;
    logic       stall, flush, redirect_valid, done;
    logic [7:0] redirect_pc;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] F_ALU = 4'b1000;  // {reg_write, mem, load, ret}
    localparam logic [3:0] F_LD  = 4'b1110;
    localparam logic [3:0] F_RET = 4'b0001;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       iv;
        logic       br;
        logic [3:0] busy;
        logic [2:0] tc;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] fl;
    } stim_t;

    typedef logic [21:0] obs_t;

    obs_t sb[$];

    pipeline_ctrl #(
        .THREADS_PER_BLOCK(4),
        .PC_BITS(8),
        .REG_ADDR_BITS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem(id_mem), .id_load(id_load), .id_ret(id_ret),
        .mem_busy(mem_busy), .branch_taken(branch_taken), .branch_target(branch_target),
        .stage_valid(stage_valid), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .done(done)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic iv, input logic [3:0] fl = 4'd0,
                                 input logic [3:0] rd = 4'd0, input logic [3:0] rs = 4'hF,
                                 input logic [3:0] rt = 4'hF, input logic br = 1'b0,
                                 input logic [3:0] busy = 4'd0, input logic [2:0] tc = 3'd4,
                                 input logic st = 1'b0, input logic rst = 1'b0);
        stim_t m;
        m.rst = rst; m.st = st; m.iv = iv; m.br = br; m.busy = busy; m.tc = tc;
        m.rd = rd; m.rs = rs; m.rt = rt; m.fl = fl;
        return m;
    endfunction

    function automatic obs_t ex(input logic [4:0] sv, input logic stl = 1'b0,
                                input logic rdy = 1'b1, input logic fl = 1'b0,
                                input logic rv = 1'b0, input logic dn = 1'b0,
                                input logic [1:0] frs = 2'b00, input logic [1:0] frt = 2'b00,
                                input logic [7:0] rpc = 8'h00);
        return {sv, stl, rdy, fl, rv, dn, frs, frt, rpc};
    endfunction

    function automatic obs_t obs();
        return {stage_valid, stall, if_ready, flush, redirect_valid, done,
                fwd_rs_sel, fwd_rt_sel, redirect_pc};
    endfunction

    task automatic apply(input stim_t s);
        reset         = s.rst;
        start         = s.st;
        if_valid      = s.iv;
        if_pc         = if_pc + 8'd1;
        branch_taken  = s.br;
        branch_target = 8'h20;
        mem_busy      = s.busy;
        thread_count  = s.tc;
        id_rd         = s.rd;
        id_rs         = s.rs;
        id_rt         = s.rt;
        {id_reg_write, id_mem, id_load, id_ret} = s.fl;
    endtask

    task automatic test_reset();
        obs_t got;
        if_pc = 8'h00;
        @(negedge clk);
        apply(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b0, 1'b1));
        @(negedge clk);
        #1;
        got = obs();
        n_checks++;
        if (got !== ex(5'd0, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL reset: got %h want %h", got, ex(5'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_straight();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        logic [4:0] svs [13] = '{5'd0, 5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31,
                                 5'd31, 5'd30, 5'd28, 5'd24, 5'd16, 5'd0};
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b1));
        e.push_back(ex(5'd0, 1'b0, 1'b0));
        for (int i = 1; i < 13; i++) begin
            s.push_back(mk(i <= 6, F_ALU, 4'(i % 8 + 1)));
            e.push_back(ex(svs[i]));
        end
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL straight step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_hazard();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk(1'b1));                         e.push_back(ex(5'd0));
        s.push_back(mk(1'b1));                         e.push_back(ex(5'd1));
        s.push_back(mk(1'b0, F_ALU, 4'd1));            e.push_back(ex(5'd3));
        s.push_back(mk(1'b0, F_ALU, 4'd2, 4'd1, 4'd1)); e.push_back(ex(5'd6, 1'b1, 1'b0));
`ifdef FORWARDING_EN
        s.push_back(mk(1'b0, F_ALU, 4'd2, 4'd1, 4'd1));
        e.push_back(ex(5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01));
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd20));
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd8));
`else
        s.push_back(mk(1'b0, F_ALU, 4'd2, 4'd1, 4'd1)); e.push_back(ex(5'd10, 1'b1, 1'b0));
        s.push_back(mk(1'b0, F_ALU, 4'd2, 4'd1, 4'd1)); e.push_back(ex(5'd18, 1'b1, 1'b0));
        s.push_back(mk(1'b0, F_ALU, 4'd2, 4'd1, 4'd1)); e.push_back(ex(5'd2));
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd4));
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd8));
`endif
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd16));
        s.push_back(mk(1'b0));                         e.push_back(ex(5'd0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL hazard step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_mem_stall();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        logic [2:0] tcs [2] = '{3'd3, 3'd4};
        logic [3:0] bss [2] = '{4'b0100, 4'b1000};
        logic [2:0] tcr [2] = '{3'd2, 3'd0};
        logic [3:0] bsr [2] = '{4'b0100, 4'b1111};
        for (int p = 0; p < 2; p++) begin
            s.push_back(mk(1'b1));             e.push_back(ex(5'd0));
            s.push_back(mk(1'b0));             e.push_back(ex(5'd1));
            s.push_back(mk(1'b0, F_LD, 4'd3)); e.push_back(ex(5'd2));
            s.push_back(mk(1'b0));             e.push_back(ex(5'd4));
            s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, bss[p], tcs[p]));
            e.push_back(ex(5'd8, 1'b1, 1'b0));
            s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, bss[p], tcs[p]));
            e.push_back(ex(5'd8, 1'b1, 1'b0));
            s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, bsr[p], tcr[p]));
            e.push_back(ex(5'd8));
            s.push_back(mk(1'b0));             e.push_back(ex(5'd16));
            s.push_back(mk(1'b0));             e.push_back(ex(5'd0));
        end
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL mem_stall step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk(1'b1)); e.push_back(ex(5'd0));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd1));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd3));
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b1));
        e.push_back(ex(5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h20));
        // branch_taken with EX empty must not flush
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b1)); e.push_back(ex(5'd8));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd17));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd2));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd4));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd8));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd16));
        s.push_back(mk(1'b0)); e.push_back(ex(5'd0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL branch step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_branch_mem_stall();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk(1'b1));             e.push_back(ex(5'd0));
        s.push_back(mk(1'b1));             e.push_back(ex(5'd1));
        s.push_back(mk(1'b0, F_LD, 4'd3)); e.push_back(ex(5'd3));
        s.push_back(mk(1'b0));             e.push_back(ex(5'd6));
        s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b1, 4'b0001));
        e.push_back(ex(5'd12, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b1));
        e.push_back(ex(5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h20));
        s.push_back(mk(1'b0));             e.push_back(ex(5'd24));
        s.push_back(mk(1'b0));             e.push_back(ex(5'd16));
        s.push_back(mk(1'b0));             e.push_back(ex(5'd0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL branch_mem_stall step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_ret();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk(1'b1));              e.push_back(ex(5'd0));
        s.push_back(mk(1'b1));              e.push_back(ex(5'd1));
        s.push_back(mk(1'b1, F_ALU, 4'd4)); e.push_back(ex(5'd3));
        s.push_back(mk(1'b1, F_RET));       e.push_back(ex(5'd7, 1'b0, 1'b0));
        s.push_back(mk(1'b1));              e.push_back(ex(5'd12, 1'b0, 1'b0));
        s.push_back(mk(1'b1));              e.push_back(ex(5'd24, 1'b0, 1'b0));
        s.push_back(mk(1'b1));              e.push_back(ex(5'd16, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b1));
        e.push_back(ex(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0));              e.push_back(ex(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b1));              e.push_back(ex(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL ret step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk(1'b0, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b0, 1'b1));
        e.push_back(ex(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b1));
        e.push_back(ex(5'd0, 1'b0, 1'b0));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd0));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd1));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd3));
        s.push_back(mk(1'b1, 4'd0, 4'd0, 4'hF, 4'hF, 1'b0, 4'd0, 3'd4, 1'b0, 1'b1));
        e.push_back(ex(5'd7));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd0, 1'b0, 1'b0));
        s.push_back(mk(1'b1)); e.push_back(ex(5'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); sb.push_back(e[i]); #1;
            want = sb.pop_front(); got = obs(); n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_mid_run step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_hazard();
        test_mem_stall();
        test_branch();
        test_branch_mem_stall();
        test_ret();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
